dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single-port data RAM between the CPU M stage and a DMA/debug master.
//  The CPU side drives word address, byte enables and store data; its byte enables come
//  from the store-decode logic. The CPU side receives the raw read word, which the
//  load-extension logic then sign-extends.
//  Sequences each access through a fixed-latency RAM, stalls the pipeline while the CPU
//  waits, and bounds DMA starvation.
// PARAMETERS
//  ADDR_W        32  byte-address width; RAM is word-addressed with ADDR_W-2 bits
//  RAM_LAT       1   cycles from ram_en (read) to valid ram_rdata; legal range >=1
//  STARVE_LIMIT  4   consecutive CPU wins while DMA is pending before DMA is forced; >=1
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        asynchronous, active-high
//  cpu_req    in   1        M-stage load/store pending; held until cpu_done
//  cpu_be     in   4        byte enables; 4'b0000 = load
//  cpu_addr   in   ADDR_W   byte address (ALU result)
//  cpu_wdata  in   32       store data, already lane-aligned
//  cpu_stall  out  1        freeze the pipeline
//  cpu_done   out  1        one-cycle completion pulse
//  cpu_rdata  out  32       raw read word; valid from cpu_done, held until next capture
//  dma_req    in   1        DMA access pending; held until dma_done
//  dma_be     in   4        byte enables; 0 = read
//  dma_addr   in   ADDR_W   byte address
//  dma_wdata  in   32       write data
//  dma_done   out  1        one-cycle completion pulse
//  dma_rdata  out  32       raw read word; same hold rule as cpu_rdata
//  ram_en     out  1        RAM access strobe
//  ram_we     out  4        RAM byte write enables
//  ram_addr   out  ADDR_W-2 word address = latched addr[ADDR_W-1:2]
//  ram_wdata  out  32       RAM write data
//  ram_rdata  in   32       RAM read data
// BEHAVIOUR
//  - Reset (async): state IDLE; every output 0, including rdata regs; starve_cnt 0.
//  - FSM states: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE. Only one transaction is in flight.
//  - IDLE, cycle t:
//    - Sample the requests; the winner's be/addr/wdata and the owner are latched.
//    - If any request is present, the next state is ISSUE.
//  - Arbitration:
//    - Only one request present: that master wins.
//    - Both present: CPU wins unless starve_cnt == STARVE_LIMIT.
//    - starve_cnt increments on each CPU win while DMA is pending.
//    - starve_cnt clears on any DMA grant; it saturates at STARVE_LIMIT.
//  - ISSUE (t+1):
//    - ram_en=1, ram_we=latched be, ram_addr and ram_wdata from the latch. Outside ISSUE,
//      ram_en=0 and ram_we=0.
//    - be!=0: go to DONE. be==0: go to WAIT with cnt=RAM_LAT.
//  - WAIT:
//    - cnt decrements each cycle.
//    - When cnt==1, ram_rdata is captured into the owner's rdata reg; the next state is DONE.
//  - DONE: the owner's done pulse is 1 for exactly this cycle; the next state is IDLE.
//    - Write latency req->done: 2 cycles.
//    - Read latency req->done: 2+RAM_LAT cycles.
//  - Re-arbitration never occurs in DONE. Minimum spacing between grants is one IDLE
//    cycle, which prevents a still-asserted req from double-issuing.
//  - cpu_stall = cpu_req & ~cpu_done. It is combinational from registered state; it is
//    high during DMA service.
//  - Payload is latched at grant. Input changes after grant are ignored.
//  - A req dropped before done is a protocol violation. The transaction still completes
//    and the done pulse still fires.
//  - Address bits [1:0] are ignored; lane selection is carried entirely by be.
//  - The non-owner's rdata reg is never modified.
//  - Reset mid-transaction: outputs go to 0 immediately and no done pulse is issued.
//    A write whose ISSUE cycle already occurred stays committed in RAM.
// STRUCTURE
//  - define.v gains: FSM encodings `ARB_IDLE/`ARB_ISSUE/`ARB_WAIT/`ARB_DONE (2-bit),
//    owner codes `OWN_CPU=0/`OWN_DMA=1.
//  - One sub-module: dm_arb_pick.
//    - Combinational winner select plus the registered starve_cnt.
//    - Inputs: cpu_req, dma_req, idle.
//    - Outputs: grant_dma, grant_valid.
//  - Everything else (FSM, payload latch, latency counter, rdata regs) stays in
//    dm_port_arbiter.
// TESTING
//  1. CPU sw: cpu_be=1111, addr=0x00000010, wdata=0xDEADBEEF at t.
//     -> t+1: ram_en=1, ram_addr=0x4, ram_we=1111.
//     -> t+2: cpu_done=1.
//     -> cpu_stall=1 at t and t+1, and 0 at t+2.
//  2. CPU lw, RAM_LAT=1, addr=0x8, ram_rdata=0x12345678 at t+2.
//     -> cpu_rdata=0x12345678 and cpu_done=1 at t+3; cpu_rdata held afterwards.
//  3. RAM_LAT=3, CPU load.
//     -> ram_rdata is captured at t+4, cpu_done at t+5, with no ram_en beyond t+1.
//  4. STARVE_LIMIT=2, cpu_req and dma_req both continuously asserted.
//     -> Grant order CPU, CPU, DMA, CPU, CPU, DMA.
//     -> dma_done is never more than 3 grants after dma_req rises.
//  5. DMA-only sb: dma_be=0100, addr=0x22.
//     -> ram_we=0100 and ram_addr=0x8 at t+1; dma_done at t+2; cpu_stall=0 throughout.
//  6. Reset asserted in WAIT of a CPU read.
//     -> All outputs 0 asynchronously, no cpu_done pulse, and cpu_rdata=0.
//     -> After release, a new CPU write completes in 2 cycles.

Source files
------------

// File: rtl/dm_port_arbiter_pkg.sv
// Shared types for the data-RAM port arbiter: FSM encoding and owner codes.
package dm_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  function automatic logic [3:0] issue_we(input arb_state_t s, input logic [3:0] be);
    return (s == ARB_ISSUE) ? be : 4'b0000;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Winner select between CPU and DMA, with a saturating starvation counter that
// forces a DMA grant after STARVE_LIMIT consecutive CPU wins over a pending DMA.
module dm_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic idle,
  output logic grant_dma,
  output logic grant_valid
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved     = (starve_cnt == LIMIT);
  assign grant_valid = idle & (cpu_req | dma_req);
  assign grant_dma   = idle & dma_req & (~cpu_req | starved);

  // A CPU win can never happen while starved with DMA pending, so the counter
  // saturates naturally at LIMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_valid) begin
      if (grant_dma)
        starve_cnt <= '0;
      else if (dma_req && !starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data RAM between the CPU M stage and a DMA/debug master,
// one transaction at a time through a fixed-latency RAM.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int RAM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic [3:0]        dma_be,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_done,
  output logic [31:0]       dma_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RAM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t        state, state_nxt;
  logic              owner_q;
  logic [3:0]        be_q;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              grant_dma, grant_valid;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{cpu_addr[1:0], dma_addr[1:0]};

  dm_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .dma_req     (dma_req),
    .idle        (state == ARB_IDLE),
    .grant_dma   (grant_dma),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (grant_valid) state_nxt = ARB_ISSUE;
      ARB_ISSUE: state_nxt = (be_q != 4'b0000) ? ARB_DONE : ARB_WAIT;
      ARB_WAIT:  if (cnt_q == CNT_ONE) state_nxt = ARB_DONE;
      ARB_DONE:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Payload is captured only at grant, so requester changes afterwards are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= OWN_CPU;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      if (grant_valid) begin
        owner_q <= grant_dma;
        be_q    <= grant_dma ? dma_be : cpu_be;
        addr_q  <= grant_dma ? dma_addr[ADDR_W-1:2] : cpu_addr[ADDR_W-1:2];
        wdata_q <= grant_dma ? dma_wdata : cpu_wdata;
      end
      if (state == ARB_ISSUE && be_q == 4'b0000) begin
        cnt_q <= LAT_INIT;
      end else if (state == ARB_WAIT) begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_ONE) begin
          if (owner_q == OWN_DMA) dma_rdata <= ram_rdata;
          else                    cpu_rdata <= ram_rdata;
        end
      end
    end
  end

  // Handshake: a master holds req (and payload) until its one-cycle done pulse;
  // the bench-visible grant happens only in IDLE, so a held req never double-issues.
  assign cpu_done  = (state == ARB_DONE) && (owner_q == OWN_CPU);
  assign dma_done  = (state == ARB_DONE) && (owner_q == OWN_DMA);
  assign cpu_stall = cpu_req & ~cpu_done & ~reset;
  assign ram_en    = (state == ARB_ISSUE);
  assign ram_we    = issue_we(state, be_q);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: two instances (RAM_LAT=1/STARVE_LIMIT=2 and
// RAM_LAT=3/STARVE_LIMIT=4) share stimulus; read data and grant order go through queues.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, dma_req;
  logic [3:0]  cpu_be, dma_be;
  logic [31:0] cpu_addr, dma_addr, cpu_wdata, dma_wdata, ram_rdata;

  logic        a_cpu_stall, a_cpu_done, a_dma_done, a_ram_en;
  logic [31:0] a_cpu_rdata, a_dma_rdata, a_ram_wdata;
  logic [3:0]  a_ram_we;
  logic [29:0] a_ram_addr;
  logic [1:0]  a_state_dbg;

  logic        b_cpu_stall, b_cpu_done, b_dma_done, b_ram_en;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_ram_wdata;
  logic [3:0]  b_ram_we;
  logic [29:0] b_ram_addr;
  logic [1:0]  b_state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [0:0]  own_q[$];

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(32), .RAM_LAT(1), .STARVE_LIMIT(2)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(a_cpu_stall), .cpu_done(a_cpu_done), .cpu_rdata(a_cpu_rdata),
    .dma_req(dma_req), .dma_be(dma_be), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(a_dma_done), .dma_rdata(a_dma_rdata),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .ram_rdata(ram_rdata), .state_dbg(a_state_dbg)
  );

  dm_port_arbiter #(.ADDR_W(32), .RAM_LAT(3), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(b_cpu_stall), .cpu_done(b_cpu_done), .cpu_rdata(b_cpu_rdata),
    .dma_req(dma_req), .dma_be(dma_be), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(b_dma_done), .dma_rdata(b_dma_rdata),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_rdata(ram_rdata), .state_dbg(b_state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      to_drive();
      ram_rdata = $urandom();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_be = '0; dma_addr = '0; dma_wdata = '0;
    ram_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    to_neg();
    check("rst_a_ctl",   {a_cpu_stall, a_cpu_done, a_dma_done, a_ram_en, a_ram_we, a_state_dbg}, 0);
    check("rst_a_rdata", {a_cpu_rdata, a_dma_rdata}, 0);
    check("rst_a_ram",   {a_ram_addr, a_ram_wdata}, 0);
    check("rst_b_ctl",   {b_cpu_stall, b_cpu_done, b_dma_done, b_ram_en, b_ram_we, b_state_dbg}, 0);
    check("rst_b_rdata", {b_cpu_rdata, b_dma_rdata}, 0);
    check("rst_b_ram",   {b_ram_addr, b_ram_wdata}, 0);
    to_drive();
    reset = 1'b0;
    idle_cycles(2);

    // CPU store word; payload changes after grant must be ignored
    cpu_req = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    to_neg();
    check("t1_stall_t", a_cpu_stall, 1);
    check("t1_en_t", a_ram_en, 0);
    to_drive();
    cpu_addr = 32'h1F0; cpu_wdata = 32'h0;
    to_neg();
    check("t1_en", a_ram_en, 1);
    check("t1_addr", a_ram_addr, 30'h4);
    check("t1_we", a_ram_we, 4'hF);
    check("t1_wdata", a_ram_wdata, 32'hDEADBEEF);
    check("t1_stall_t1", a_cpu_stall, 1);
    check("t1_done_t1", a_cpu_done, 0);
    to_drive();
    to_neg();
    check("t1_done", a_cpu_done, 1);
    check("t1_stall_t2", a_cpu_stall, 0);
    check("t1_en_off", {a_ram_en, a_ram_we}, 0);
    to_drive();
    cpu_req = 1'b0; cpu_be = '0;
    to_neg();
    check("t1_done_pulse", a_cpu_done, 0);
    idle_cycles(3);

    // CPU load, RAM_LAT=1
    cpu_req = 1'b1; cpu_be = 4'h0; cpu_addr = 32'h8;
    exp_q.push_back(32'h12345678);
    to_neg();
    to_drive();
    to_neg();
    check("t2_issue", {a_ram_en, a_ram_we}, {1'b1, 4'h0});
    check("t2_addr", a_ram_addr, 30'h2);
    to_drive();
    ram_rdata = 32'h12345678;
    to_neg();
    check("t2_done_early", a_cpu_done, 0);
    check("t2_state_wait", a_state_dbg, 2'd2);
    to_drive();
    ram_rdata = $urandom();
    to_neg();
    check("t2_done", a_cpu_done, 1);
    check("t2_rdata", a_cpu_rdata, exp_q.pop_front());
    check("t2_dma_rdata_untouched", a_dma_rdata, 0);
    to_drive();
    cpu_req = 1'b0;
    to_neg();
    check("t2_rdata_hold", a_cpu_rdata, 32'h12345678);
    check("t2_done_pulse", a_cpu_done, 0);
    idle_cycles(6);

    // DMA load; CPU read data must stay put
    dma_req = 1'b1; dma_be = 4'h0; dma_addr = 32'h30;
    exp_q.push_back(32'h0BADF00D);
    to_neg();
    check("t2b_stall", a_cpu_stall, 0);
    to_drive();
    to_neg();
    check("t2b_issue", {a_ram_en, a_ram_addr}, {1'b1, 30'hC});
    to_drive();
    ram_rdata = 32'h0BADF00D;
    to_neg();
    to_drive();
    ram_rdata = $urandom();
    to_neg();
    check("t2b_done", {a_dma_done, a_cpu_done}, 2'b10);
    check("t2b_dma_rdata", a_dma_rdata, exp_q.pop_front());
    check("t2b_cpu_rdata_kept", a_cpu_rdata, 32'h12345678);
    to_drive();
    dma_req = 1'b0;
    idle_cycles(6);

    // CPU load, RAM_LAT=3 (instance b)
    cpu_req = 1'b1; cpu_be = 4'h0; cpu_addr = 32'h0C;
    exp_q.push_back(32'hCAFEF00D);
    to_neg();
    to_drive();
    to_neg();
    check("t3_issue", {b_ram_en, b_ram_addr}, {1'b1, 30'h3});
    to_drive();
    to_neg();
    check("t3_en_t2", b_ram_en, 0);
    to_drive();
    to_neg();
    check("t3_t3", {b_ram_en, b_cpu_done}, 0);
    to_drive();
    ram_rdata = 32'hCAFEF00D;
    to_neg();
    check("t3_t4", {b_ram_en, b_cpu_done, b_state_dbg}, {2'b00, 2'd2});
    to_drive();
    ram_rdata = $urandom();
    to_neg();
    check("t3_done", b_cpu_done, 1);
    check("t3_rdata", b_cpu_rdata, exp_q.pop_front());
    check("t3_stall", b_cpu_stall, 0);
    to_drive();
    cpu_req = 1'b0;
    idle_cycles(8);

    // Starvation bound, STARVE_LIMIT=2 (instance a)
    own_q.push_back(1'b0); own_q.push_back(1'b0); own_q.push_back(1'b1);
    own_q.push_back(1'b0); own_q.push_back(1'b0); own_q.push_back(1'b1);
    cpu_req = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h40; cpu_wdata = 32'h11111111;
    dma_req = 1'b1; dma_be = 4'hF; dma_addr = 32'h80; dma_wdata = 32'h22222222;
    for (int c = 0; c < 40 && own_q.size() > 0; c++) begin
      to_neg();
      if (a_cpu_done || a_dma_done) begin
        check("t4_excl", {a_cpu_done, a_dma_done}, a_dma_done ? 2'b01 : 2'b10);
        check("t4_grant_order", a_dma_done, own_q.pop_front());
      end
      if (own_q.size() > 0) to_drive();
    end
    check("t4_grants_left", own_q.size(), 0);
    to_drive();
    cpu_req = 1'b0; dma_req = 1'b0;
    idle_cycles(6);

    // DMA-only store byte, lane 2
    dma_req = 1'b1; dma_be = 4'b0100; dma_addr = 32'h22; dma_wdata = 32'h00AA0000;
    to_neg();
    check("t5_stall_t", a_cpu_stall, 0);
    to_drive();
    to_neg();
    check("t5_issue", {a_ram_en, a_ram_we, a_ram_addr}, {1'b1, 4'b0100, 30'h8});
    check("t5_wdata", a_ram_wdata, 32'h00AA0000);
    check("t5_stall_t1", a_cpu_stall, 0);
    to_drive();
    to_neg();
    check("t5_done", {a_dma_done, a_cpu_done, a_cpu_stall}, 3'b100);
    to_drive();
    dma_req = 1'b0; dma_be = '0;
    idle_cycles(4);

    // Reset during WAIT of a CPU read
    cpu_req = 1'b1; cpu_be = 4'h0; cpu_addr = 32'h14;
    to_neg();
    to_drive();
    to_neg();
    to_drive();
    to_neg();
    check("t6_in_wait", a_state_dbg, 2'd2);
    ram_rdata = 32'h55AA55AA;
    reset = 1'b1;
    #1;
    check("t6_a_ctl", {a_cpu_stall, a_cpu_done, a_dma_done, a_ram_en, a_ram_we, a_state_dbg}, 0);
    check("t6_a_rdata", {a_cpu_rdata, a_dma_rdata}, 0);
    check("t6_a_ram", {a_ram_addr, a_ram_wdata}, 0);
    check("t6_b_ctl", {b_cpu_stall, b_cpu_done, b_ram_en, b_cpu_rdata}, 0);
    to_drive();
    cpu_req = 1'b0;
    to_neg();
    check("t6_no_done", {a_cpu_done, a_cpu_rdata}, 0);
    to_drive();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h20; cpu_wdata = 32'h01020304;
    to_neg();
    check("t6w_t", {a_cpu_done, a_ram_en}, 0);
    to_drive();
    to_neg();
    check("t6w_issue", {a_ram_en, a_ram_addr, a_ram_wdata}, {1'b1, 30'h8, 32'h01020304});
    to_drive();
    to_neg();
    check("t6w_done", a_cpu_done, 1);
    to_drive();
    cpu_req = 1'b0; cpu_be = '0;
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
